// File: rtl/doorlock_pkg.sv
// Shared definitions for the keypad door lock: state encoding and BCD helpers.
package doorlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_CHECK = 3'd2,
        ST_OPEN  = 3'd3,
        ST_FAIL  = 3'd4,
        ST_LOCK  = 3'd5
    } state_t;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    function automatic logic [3:0] bcd_nibble(input logic [31:0] code, input logic [2:0] idx);
        return code[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] onehot_to_bcd(input logic [9:0] oh);
        logic [3:0] r_val;
        int         n_set;
        r_val = BCD_INVALID;
        n_set = 0;
        for (int i = 0; i < 10; i++) begin
            if (oh[i]) begin
                r_val = 4'(i);
                n_set++;
            end
        end
        if (n_set != 1) begin
            r_val = BCD_INVALID;
        end
        return r_val;
    endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Shared load/decrement down-counter; expired is high while running and at zero.
module doorlock_timer
    import doorlock_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] r_cnt;
    logic         r_run;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (load) begin
            r_cnt <= load_val;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign expired = r_run && (r_cnt == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// Keypad door lock sequencer: code check, timed open window, optional lockout.
// Attempt counting and the lockout state exist only when DOORLOCK_LOCKOUT_EN is defined.
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int          CODE_LEN     = 4,
    parameter logic [31:0] CODE         = 32'h0000_1297,
    parameter int          OPEN_CYC     = 50_000_000,
    parameter int          LOCK_CYC     = 250_000_000,
    parameter int          ENTRY_TO_CYC = 250_000_000,
    parameter int          MAX_FAIL     = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [9:0] bt,
    input  logic       btstar,
    output logic       unlock,
    output logic       lockout,
    output logic       err,
    output logic [3:0] dig_cnt
);

    localparam int T_MAX0 = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
    localparam int T_MAX  = (T_MAX0 > ENTRY_TO_CYC) ? T_MAX0 : ENTRY_TO_CYC;
    localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Loading period-1 makes the state last exactly period cycles.
    localparam logic [TW-1:0] LD_OPEN  = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0] LD_LOCK  = TW'(LOCK_CYC - 1);
    localparam logic [TW-1:0] LD_ENTRY = TW'(ENTRY_TO_CYC - 1);
    localparam logic [3:0]    LEN      = 4'(CODE_LEN);
    localparam logic [3:0]    LEN_SAT  = 4'(CODE_LEN + 1);

    state_t        r_state, w_nxt;
    logic [3:0]    r_dig_cnt, w_dig_nxt;
    logic          r_miss, w_miss_nxt;
    logic          r_unlock, r_err, r_lockout;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_expired;
    logic          w_digit;
    logic [3:0]    w_key;
    logic          w_bad;

    function automatic logic [3:0] exp_digit(input logic [3:0] idx);
        logic [3:0] sel;
        sel = LEN - 4'd1 - idx;
        if (idx < LEN) begin
            return bcd_nibble(CODE, sel[2:0]);
        end
        return BCD_INVALID;
    endfunction

    // A star in the same cycle as a digit takes precedence.
    assign w_digit = (bt != 10'd0) && !btstar;
    assign w_key   = onehot_to_bcd(bt);
    assign w_bad   = (w_key == BCD_INVALID) || (w_key != exp_digit(r_dig_cnt)) ||
                     (r_dig_cnt >= LEN);

`ifdef DOORLOCK_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    logic [FW-1:0] r_fail_cnt, w_fail_nxt, w_fail_inc;
    assign w_fail_inc = r_fail_cnt + 1'b1;
`endif

    always_comb begin
        w_nxt      = r_state;
        w_dig_nxt  = r_dig_cnt;
        w_miss_nxt = r_miss;
        w_load     = 1'b0;
        w_load_val = LD_ENTRY;
`ifdef DOORLOCK_LOCKOUT_EN
        w_fail_nxt = r_fail_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_digit) begin
                    w_miss_nxt = w_bad;
                    w_dig_nxt  = 4'd1;
                    w_load     = 1'b1;
                    w_nxt      = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (w_expired) begin
                    w_nxt = ST_IDLE;
                end else if (btstar) begin
                    w_nxt = ST_CHECK;
                end else if (w_digit) begin
                    w_miss_nxt = r_miss | w_bad;
                    w_dig_nxt  = (r_dig_cnt >= LEN_SAT) ? LEN_SAT : r_dig_cnt + 4'd1;
                    w_load     = 1'b1;
                end
            end
            ST_CHECK: begin
                if (!r_miss && r_dig_cnt == LEN) begin
                    w_nxt      = ST_OPEN;
                    w_load     = 1'b1;
                    w_load_val = LD_OPEN;
`ifdef DOORLOCK_LOCKOUT_EN
                    w_fail_nxt = '0;
`endif
                end else begin
                    w_nxt = ST_FAIL;
                end
            end
            ST_OPEN: begin
                if (w_expired) begin
                    w_nxt = ST_IDLE;
                end
            end
            ST_FAIL: begin
`ifdef DOORLOCK_LOCKOUT_EN
                w_fail_nxt = w_fail_inc;
                if (w_fail_inc == FW'(MAX_FAIL)) begin
                    w_nxt      = ST_LOCK;
                    w_load     = 1'b1;
                    w_load_val = LD_LOCK;
                end else begin
                    w_nxt = ST_IDLE;
                end
`else
                w_nxt = ST_IDLE;
`endif
            end
`ifdef DOORLOCK_LOCKOUT_EN
            ST_LOCK: begin
                if (w_expired) begin
                    w_nxt      = ST_IDLE;
                    w_fail_nxt = '0;
                end
            end
`endif
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase
        if (w_nxt == ST_IDLE) begin
            w_dig_nxt  = 4'd0;
            w_miss_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state   <= ST_IDLE;
            r_dig_cnt <= 4'd0;
            r_miss    <= 1'b0;
            r_unlock  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_dig_cnt <= w_dig_nxt;
            r_miss    <= w_miss_nxt;
            r_unlock  <= (w_nxt == ST_OPEN);
            r_err     <= (w_nxt == ST_FAIL);
        end
    end

`ifdef DOORLOCK_LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_fail_cnt <= '0;
            r_lockout  <= 1'b0;
        end else begin
            r_fail_cnt <= w_fail_nxt;
            r_lockout  <= (w_nxt == ST_LOCK);
        end
    end
`else
    assign r_lockout = 1'b0;
`endif

    doorlock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    assign unlock  = r_unlock;
    assign lockout = r_lockout;
    assign err     = r_err;
    assign dig_cnt = r_dig_cnt;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed bench for doorlock_ctrl with short timer periods.
module tb_doorlock_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [9:0] bt = 10'd0;
    logic       btstar = 1'b0;
    logic       unlock, lockout, err;
    logic [3:0] dig_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int mon_unl = 0;
    int mon_err = 0;
    int mon_lck = 0;
    int s_unl, s_err, s_lck;

    doorlock_ctrl #(
        .CODE_LEN     (4),
        .CODE         (32'h1297),
        .OPEN_CYC     (8),
        .LOCK_CYC     (16),
        .ENTRY_TO_CYC (32),
        .MAX_FAIL     (3)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .bt      (bt),
        .btstar  (btstar),
        .unlock  (unlock),
        .lockout (lockout),
        .err     (err),
        .dig_cnt (dig_cnt)
    );

    always #5 clk = ~clk;

    // Running high-cycle counts of each output, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (unlock)  mon_unl++;
        if (err)     mon_err++;
        if (lockout) mon_lck++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [9:0] b, input logic s);
        @(negedge clk);
        bt = b;
        btstar = s;
        @(negedge clk);
        bt = 10'd0;
        btstar = 1'b0;
    endtask

    task automatic enter_code(input logic [31:0] code, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            press(10'd1 << code[k*4 +: 4], 1'b0);
        end
    endtask

    task automatic snap();
        s_unl = mon_unl;
        s_err = mon_err;
        s_lck = mon_lck;
    endtask

    initial begin
        idle(3);
        check("rst_unlock", unlock, 0);
        check("rst_lockout", lockout, 0);
        check("rst_err", err, 0);
        check("rst_dig_cnt", dig_cnt, 0);
        n_rst = 1'b1;
        idle(2);

        // Correct code opens for exactly 8 cycles, starting two edges after star.
        snap();
        press(10'd1 << 1, 1'b0); check("ok_dig1", dig_cnt, 1);
        press(10'd1 << 2, 1'b0); check("ok_dig2", dig_cnt, 2);
        press(10'd1 << 9, 1'b0); check("ok_dig3", dig_cnt, 3);
        press(10'd1 << 7, 1'b0); check("ok_dig4", dig_cnt, 4);
        press(10'd0, 1'b1);
        check("ok_check_unlock", unlock, 0);
        idle(1);
        check("ok_unlock_rise", unlock, 1);
        idle(12);
        check("ok_unlock_len", mon_unl - s_unl, 8);
        check("ok_no_err", mon_err - s_err, 0);
        check("ok_idle_dig", dig_cnt, 0);

        // Wrong second digit
        snap();
        enter_code(32'h1397, 4);
        press(10'd0, 1'b1);
        check("wr_check_err", err, 0);
        idle(1);
        check("wr_err", err, 1);
        check("wr_unlock", unlock, 0);
        idle(1);
        check("wr_err_fall", err, 0);
        check("wr_idle_dig", dig_cnt, 0);
        check("wr_err_len", mon_err - s_err, 1);

        // Too many digits, with dig_cnt saturation
        snap();
        enter_code(32'h12975, 5);
        check("long_dig5", dig_cnt, 5);
        press(10'd1 << 5, 1'b0);
        check("long_sat", dig_cnt, 5);
        press(10'd0, 1'b1);
        idle(3);
        check("long_err", mon_err - s_err, 1);
        check("long_unlock", mon_unl - s_unl, 0);

        // Correct code clears the failure count
        snap();
        enter_code(32'h1297, 4);
        press(10'd0, 1'b1);
        idle(12);
        check("reopen_len", mon_unl - s_unl, 8);

        // Too few digits
        snap();
        enter_code(32'h129, 3);
        press(10'd0, 1'b1);
        idle(3);
        check("short_err", mon_err - s_err, 1);
        check("short_unlock", mon_unl - s_unl, 0);

        // Two keys at once is a mismatching digit
        snap();
        press(10'd1 << 1, 1'b0);
        press(10'h006, 1'b0);
        check("multi_dig", dig_cnt, 2);
        enter_code(32'h97, 2);
        press(10'd0, 1'b1);
        idle(3);
        check("multi_err", mon_err - s_err, 1);
        check("multi_unlock", mon_unl - s_unl, 0);

        // Star together with a digit is star only
        snap();
        enter_code(32'h1297, 4);
        press(10'd1 << 5, 1'b1);
        check("star_bt_dig", dig_cnt, 4);
        idle(1);
        check("star_bt_unlock", unlock, 1);
        idle(12);
        check("star_bt_len", mon_unl - s_unl, 8);
        check("star_bt_err", mon_err - s_err, 0);

        // Entry timeout returns to idle silently
        snap();
        enter_code(32'h12, 2);
        idle(31);
        check("to_before", dig_cnt, 2);
        idle(1);
        check("to_after", dig_cnt, 0);
        check("to_no_err", mon_err - s_err, 0);

        // Three consecutive failures
        enter_code(32'h1397, 4);
        press(10'd0, 1'b1);
        idle(2);
        enter_code(32'h1397, 4);
        press(10'd0, 1'b1);
        idle(2);
        snap();
        enter_code(32'h1397, 4);
        press(10'd0, 1'b1);
        idle(1);
        check("lk_err", err, 1);
        idle(1);
`ifdef DOORLOCK_LOCKOUT_EN
        check("lk_rise", lockout, 1);
        enter_code(32'h1297, 4);
        check("lk_ignore_dig", dig_cnt, 0);
        press(10'd0, 1'b1);
        check("lk_ignore_unlock", unlock, 0);
        idle(10);
        check("lk_fall", lockout, 0);
        check("lk_len", mon_lck - s_lck, 16);
        check("lk_no_open", mon_unl - s_unl, 0);
`else
        check("lk_absent", lockout, 0);
`endif
        enter_code(32'h1297, 4);
        press(10'd0, 1'b1);
        idle(1);
        check("lk_after_open", unlock, 1);
        idle(12);
`ifndef DOORLOCK_LOCKOUT_EN
        check("lk_never", mon_lck - s_lck, 0);
`endif

        // Reset in the middle of the open window
        enter_code(32'h1297, 4);
        press(10'd0, 1'b1);
        idle(4);
        check("rs_open", unlock, 1);
        n_rst = 1'b0;
        idle(1);
        check("rs_unlock", unlock, 0);
        check("rs_lockout", lockout, 0);
        check("rs_err", err, 0);
        check("rs_dig_cnt", dig_cnt, 0);
        n_rst = 1'b1;
        idle(2);
        check("rs_stays_closed", unlock, 0);
        press(10'd1 << 1, 1'b0);
        check("rs_alive", dig_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
